trace_replay_ctrl: RTL
======================

Name: trace_replay_ctrl

Overview:
- Sequencer that walks the trace ROM from address 0 and turns each entry into PIFO push transactions or timed idle gaps.
- Drives the ROM's read-enable and address, and decodes the returned word.
- Presents pushes to the PIFO over a valid/ready handshake.
- Sits between the trace ROM and the BMW PIFO push port in the replay testbench/top.

Parameters:
- PTW, 16, payload and priority width.
- MTW, 16, metadata width.
- TREE_NUM, 4, number of trees; TREE_NUM_BITS = $clog2(TREE_NUM).
- ROM_SIZE, 8, ROM depth; ROM_WIDTH = $clog2(ROM_SIZE).
- IDLECYCLE, 1024, maximum idle count; IDLECYCLE_BITS = $clog2(IDLECYCLE).
- TRACE_DATA_BITS (localparam) = max(IDLECYCLE_BITS, 2*PTW+TREE_NUM_BITS+MTW) + 2.

Ports:
- i_clk, in, 1: clock.
- i_arst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: begin replay; sampled only in IDLE or DONE.
- i_loop, in, 1: on last-address completion, wrap to address 0 instead of entering DONE.
- o_rom_read_en, out, 1: ROM read enable.
- o_rom_addr, out, ROM_WIDTH: ROM address.
- i_rom_data, in, TRACE_DATA_BITS: combinational ROM output, valid in the same cycle as the address.
- o_push_valid, out, 1: push request.
- i_push_ready, in, 1: PIFO accepts the push.
- o_push_priority, out, PTW: push priority.
- o_push_tree_id, out, TREE_NUM_BITS: push tree id.
- o_push_meta, out, MTW: push metadata.
- o_push_data, out, PTW: push payload.
- o_busy, out, 1: state is FETCH, PUSH or WAIT.
- o_done, out, 1: state is DONE.
- o_push_count, out, 32: accepted pushes since last start.

Behaviour:
- Clock is i_clk; reset is i_arst_n, asynchronous, active-low. Both are fixed.
- Entry type, taken from bits [TRACE_DATA_BITS-1:TRACE_DATA_BITS-2]:
  - 2'b01 = PACKET
  - 2'b00 = IDLE
  - 2'b11 = END
  - 2'b10 = reserved, treated as IDLE with count 0
- PACKET fields, LSB first: data [PTW-1:0], meta next MTW bits, tree_id next TREE_NUM_BITS, priority next PTW.
- IDLE count is bits [IDLECYCLE_BITS-1:0].
- Reset values: state IDLE; o_rom_read_en=0, o_rom_addr=0, o_push_valid=0, all push fields 0, o_busy=0, o_done=0, o_push_count=0, idle counter 0.
- FSM states: IDLE, FETCH, PUSH, WAIT, DONE.
  - IDLE/DONE + i_start=1 → next cycle: FETCH, addr=0, o_push_count=0, o_done=0.
  - FETCH: o_rom_read_en=1; decode i_rom_data this cycle.
    - PACKET → register the four fields; PUSH next cycle with o_push_valid=1.
    - IDLE count N → counter=N; WAIT.
    - END → DONE.
  - PUSH: o_push_valid and the fields hold stable until i_push_ready=1. On the accept cycle: o_push_count++, o_push_valid=0 next cycle, then ADVANCE.
  - WAIT: counter decrements each cycle; ADVANCE in the cycle it reads 0. N=0 gives exactly 1 WAIT cycle; count N gives N+1 WAIT cycles.
  - ADVANCE (not a state; action applied on the transition):
    - addr<ROM_SIZE-1 → addr+1, FETCH.
    - addr==ROM_SIZE-1 and i_loop=1 → addr=0, FETCH.
    - Otherwise → DONE.
- o_rom_read_en=0 in IDLE, PUSH, WAIT and DONE.
- Throughput: a PACKET with ready held high takes 2 cycles (FETCH, PUSH).
- i_start during FETCH, PUSH or WAIT is ignored.
- Async reset mid-push drops o_push_valid immediately; no partial state is retained.
- o_push_count saturates at 2^32-1.

Optional Feature:
- Macro: TRACE_REPLAY_STATS_EN.
- When defined:
  - Adds o_stall_cnt [31:0]: cycles with o_push_valid=1 && i_push_ready=0.
  - Adds o_run_cycles [31:0]: cycles with o_busy=1.
  - Both clear on accepted i_start, reset to 0, and saturate.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ROM {PACKET pri=5 tree=1 meta=0xAA data=0x1234, END}, ready=1, start pulse:
  - push_valid is high for exactly 1 cycle with fields 5/1/0xAA/0x1234.
  - o_done rises 2 cycles later; o_push_count=1.
- ROM {IDLE 3, PACKET, END}:
  - the first push_valid rises 6 cycles after the FETCH of addr 0 (1 FETCH + 4 WAIT + 1 FETCH).
  - read_en is low during WAIT.
- PACKET with ready held low for 4 cycles:
  - valid and fields stay constant for 5 cycles.
  - push_count increments once; stall counter = 4 when STATS_EN.
- ROM_SIZE=8, all 8 entries PACKET, i_loop=0:
  - 8 pushes, then DONE after addr 7.
  - With i_loop=1: addr wraps to 0 and the 9th push carries entry 0's fields.
- Reserved type 2'b10 at addr 0 followed by END:
  - 1 WAIT cycle, no push, then DONE.
- Assert i_arst_n=0 while in PUSH with valid high:
  - valid=0 and addr=0 immediately.
  - After release, no activity until i_start.

Source files
------------

// File: rtl/trace_replay_ctrl.sv
// trace_replay_ctrl: walks a trace ROM from address 0 and turns each entry into
// PIFO push transactions (valid/ready) or timed idle gaps.
//
// Ports:
//   i_clk, i_arst_n          clock, asynchronous active-low reset
//   i_start, i_loop          start replay (IDLE/DONE only), wrap at last address
//   o_rom_read_en/o_rom_addr ROM fetch request; i_rom_data is combinational
//   o_push_*/i_push_ready    push handshake and fields toward the PIFO
//   o_busy, o_done           status (FETCH/PUSH/WAIT, DONE)
//   o_push_count             accepted pushes since last start (saturating)
//
// Optional build macro TRACE_REPLAY_STATS_EN adds o_stall_cnt (valid && !ready
// cycles) and o_run_cycles (busy cycles), both saturating and cleared on start.
//
// Entry format (MSBs = type): 01 PACKET {pri, tree, meta, data}, 00 IDLE count,
// 11 END, 10 reserved (IDLE with count 0).
module trace_replay_ctrl #(
   parameter int unsigned PTW       = 16,
   parameter int unsigned MTW       = 16,
   parameter int unsigned TREE_NUM  = 4,
   parameter int unsigned ROM_SIZE  = 8,
   parameter int unsigned IDLECYCLE = 1024,
   localparam int unsigned TREE_NUM_BITS   = $clog2(TREE_NUM),
   localparam int unsigned ROM_WIDTH       = $clog2(ROM_SIZE),
   localparam int unsigned IDLECYCLE_BITS  = $clog2(IDLECYCLE),
   localparam int unsigned PKT_BITS        = 2 * PTW + TREE_NUM_BITS + MTW,
   localparam int unsigned TRACE_DATA_BITS =
      ((IDLECYCLE_BITS > PKT_BITS) ? IDLECYCLE_BITS : PKT_BITS) + 2
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic                       i_start,
   input  logic                       i_loop,
   output logic                       o_rom_read_en,
   output logic [ROM_WIDTH-1:0]       o_rom_addr,
   input  logic [TRACE_DATA_BITS-1:0] i_rom_data,
   output logic                       o_push_valid,
   input  logic                       i_push_ready,
   output logic [PTW-1:0]             o_push_priority,
   output logic [TREE_NUM_BITS-1:0]   o_push_tree_id,
   output logic [MTW-1:0]             o_push_meta,
   output logic [PTW-1:0]             o_push_data,
`ifdef TRACE_REPLAY_STATS_EN
   output logic [31:0]                o_stall_cnt,
   output logic [31:0]                o_run_cycles,
`endif
   output logic                       o_busy,
   output logic                       o_done,
   output logic [31:0]                o_push_count
);

   typedef enum logic [2:0] {StIdle, StFetch, StPush, StWait, StDone} state_e;

   localparam logic [ROM_WIDTH-1:0] LAST_ADDR = ROM_WIDTH'(ROM_SIZE - 1);

   state_e                    state;
   logic [IDLECYCLE_BITS-1:0] idle_cnt;

   // Decoded fields of the ROM word presented this cycle
   logic [1:0]                entry_type;
   logic [PTW-1:0]            rom_data_f;
   logic [MTW-1:0]            rom_meta_f;
   logic [TREE_NUM_BITS-1:0]  rom_tree_f;
   logic [PTW-1:0]            rom_pri_f;
   logic [IDLECYCLE_BITS-1:0] rom_idle_f;
   logic                      advance;
   logic                      at_last;

   always_comb begin
      entry_type = i_rom_data[TRACE_DATA_BITS-1 -: 2];
      rom_data_f = i_rom_data[PTW-1:0];
      rom_meta_f = i_rom_data[PTW +: MTW];
      rom_tree_f = i_rom_data[PTW+MTW +: TREE_NUM_BITS];
      rom_pri_f  = i_rom_data[PTW+MTW+TREE_NUM_BITS +: PTW];
      rom_idle_f = i_rom_data[IDLECYCLE_BITS-1:0];
      // Leave the current entry: push accepted, or the idle gap has expired
      advance    = ((state == StPush) && i_push_ready) ||
                   ((state == StWait) && (idle_cnt == '0));
      at_last    = (o_rom_addr == LAST_ADDR);
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state           <= StIdle;
         idle_cnt        <= '0;
         o_rom_read_en   <= 1'b0;
         o_rom_addr      <= '0;
         o_push_valid    <= 1'b0;
         o_push_priority <= '0;
         o_push_tree_id  <= '0;
         o_push_meta     <= '0;
         o_push_data     <= '0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_push_count    <= '0;
`ifdef TRACE_REPLAY_STATS_EN
         o_stall_cnt     <= '0;
         o_run_cycles    <= '0;
`endif
      end else begin
`ifdef TRACE_REPLAY_STATS_EN
         if (o_push_valid && !i_push_ready && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
         end
         if (o_busy && (o_run_cycles != '1)) begin
            o_run_cycles <= o_run_cycles + 32'd1;
         end
`endif
         unique case (state)
            StIdle, StDone: begin
               if (i_start) begin
                  state         <= StFetch;
                  o_rom_addr    <= '0;
                  o_rom_read_en <= 1'b1;
                  o_push_count  <= '0;
                  o_busy        <= 1'b1;
                  o_done        <= 1'b0;
`ifdef TRACE_REPLAY_STATS_EN
                  o_stall_cnt   <= '0;
                  o_run_cycles  <= '0;
`endif
               end
            end
            StFetch: begin
               o_rom_read_en <= 1'b0;
               unique case (entry_type)
                  2'b01: begin
                     o_push_priority <= rom_pri_f;
                     o_push_tree_id  <= rom_tree_f;
                     o_push_meta     <= rom_meta_f;
                     o_push_data     <= rom_data_f;
                     o_push_valid    <= 1'b1;
                     state           <= StPush;
                  end
                  2'b11: begin
                     state  <= StDone;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end
                  2'b00: begin
                     idle_cnt <= rom_idle_f;
                     state    <= StWait;
                  end
                  default: begin
                     idle_cnt <= '0;
                     state    <= StWait;
                  end
               endcase
            end
            StPush: begin
               if (i_push_ready) begin
                  o_push_valid <= 1'b0;
                  if (o_push_count != '1) begin
                     o_push_count <= o_push_count + 32'd1;
                  end
               end
            end
            StWait: begin
               if (idle_cnt != '0) begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            default: state <= StIdle;
         endcase

         if (advance) begin
            if (!at_last || i_loop) begin
               state         <= StFetch;
               o_rom_read_en <= 1'b1;
               o_rom_addr    <= at_last ? '0 : o_rom_addr + 1'b1;
            end else begin
               state  <= StDone;
               o_busy <= 1'b0;
               o_done <= 1'b1;
            end
         end
      end
   end

endmodule
